// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and lane helpers for the load/store port.
// Contents: size_t and lsu_state_t enums, size decode, byte-enable and lane
// replication helpers, and the misalignment predicate.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD_WAIT = 2'b01,
    RESP      = 2'b10
  } lsu_state_t;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   decode_size = SIZE_BYTE;
      2'b01:   decode_size = SIZE_HALF;
      default: decode_size = SIZE_WORD;
    endcase
  endfunction

  function automatic logic [3:0] gen_ben(input size_t sz, input logic [1:0] off);
    case (sz)
      SIZE_BYTE: gen_ben = 4'b0001 << off;
      SIZE_HALF: gen_ben = 4'b0011 << {off[1], 1'b0};
      default:   gen_ben = 4'b1111;
    endcase
  endfunction

  // Replicate right-justified store data across every lane it could occupy,
  // so the byte enables alone select the target bytes.
  function automatic logic [DATA_W-1:0] gen_lanes(input size_t sz,
                                                  input logic [DATA_W-1:0] wd);
    case (sz)
      SIZE_BYTE: gen_lanes = {4{wd[7:0]}};
      SIZE_HALF: gen_lanes = {2{wd[15:0]}};
      default:   gen_lanes = wd;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
    case (sz)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = off[0];
      default:   is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_port_if.sv
// lsu_port_if: request/response and memory port B signals of the load/store port.
// Ports: req_* (CPU request), resp_* (completion), mem_* (BRAM port B).
// Modports: slave = the lsu_port itself, master = the core/memory environment.
interface lsu_port_if #(
  parameter int unsigned AW = 13
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;

  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_fault;

  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_ben;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_addr, mem_wdata, mem_ben, mem_we
  );

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_addr, mem_wdata, mem_ben, mem_we
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational store lane/byte-enable generation and load extract/extend.
// Ports: st_* (store size/offset/data -> ben + replicated data),
//        ld_* (latched size/offset/unsigned + raw read word -> formatted load data).
module lsu_align
  import lsu_pkg::*;
(
  input  size_t       st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_ben_o,
  output logic [31:0] st_wdata_o,

  input  size_t       ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  assign st_ben_o   = gen_ben(st_size_i, st_off_i);
  assign st_wdata_o = gen_lanes(st_size_i, st_wdata_i);

  // Bring the addressed byte/half down to bit 0.
  assign shifted = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = shifted;
    case (ld_size_i)
      SIZE_BYTE: ld_data_o = {{24{~ld_unsigned_i & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: ld_data_o = {{16{~ld_unsigned_i & shifted[15]}}, shifted[15:0]};
      default:   ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_port.sv
// lsu_port: single-outstanding load/store initiator for BRAM port B.
// Ports: clk, reset (sync, active-high), bus (lsu_port_if.slave: req_*, resp_*, mem_*).
// Stores respond one cycle after accept, loads two cycles after accept.
// Build option LSU_MISALIGN_TRAP_EN: misaligned requests fault without touching
// memory; when undefined, offending low address bits are cleared and the access proceeds.
module lsu_port
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 8192
)(
  input  logic        clk,
  input  logic        reset,
  lsu_port_if.slave   bus
);

  localparam int unsigned AW = $clog2(MEM_SIZE);

  lsu_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    ld_off_q, ld_off_d;
  size_t         ld_size_q, ld_size_d;
  logic          ld_uns_q, ld_uns_d;
  logic [31:0]   rdata_q, rdata_d;

  size_t         req_sz;
  logic [1:0]    req_off;
  logic [1:0]    off_eff;
  logic          trap;
  logic          accept;
  logic [3:0]    st_ben;
  logic [31:0]   st_wdata;
  logic [31:0]   ld_data;

  assign req_sz  = decode_size(bus.req_size);
  assign req_off = bus.req_addr[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign off_eff = req_off;
  assign trap    = is_misaligned(req_sz, req_off);
`else
  // Clear only the bits that would make the access straddle its natural boundary.
  always_comb begin
    off_eff = req_off;
    case (req_sz)
      SIZE_HALF: off_eff = {req_off[1], 1'b0};
      SIZE_WORD: off_eff = 2'b00;
      default:   off_eff = req_off;
    endcase
  end
  assign trap = 1'b0;
`endif

  // Gating with reset keeps the port inert (no accept, no write) while reset is high.
  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  lsu_align u_align (
    .st_size_i     (req_sz),
    .st_off_i      (off_eff),
    .st_wdata_i    (bus.req_wdata),
    .st_ben_o      (st_ben),
    .st_wdata_o    (st_wdata),
    .ld_size_i     (ld_size_q),
    .ld_off_i      (ld_off_q),
    .ld_unsigned_i (ld_uns_q),
    .ld_rdata_i    (bus.mem_rdata),
    .ld_data_o     (ld_data)
  );

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    ld_off_d      = ld_off_q;
    ld_size_d     = ld_size_q;
    ld_uns_d      = ld_uns_q;
    rdata_d       = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    fault_d       = fault_q;
`endif
    bus.mem_addr  = addr_q;
    bus.mem_wdata = '0;
    bus.mem_ben   = 4'b0000;
    bus.mem_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d       = {bus.req_addr[AW-1:2], off_eff};
          bus.mem_addr = addr_d;
          rdata_d      = '0;
`ifdef LSU_MISALIGN_TRAP_EN
          fault_d      = trap;
`endif
          if (trap) begin
            state_d = RESP;
          end else begin
            bus.mem_ben   = st_ben;
            bus.mem_wdata = st_wdata;
            if (bus.req_we) begin
              bus.mem_we = 1'b1;
              state_d    = RESP;
            end else begin
              ld_off_d  = off_eff;
              ld_size_d = req_sz;
              ld_uns_d  = bus.req_unsigned;
              state_d   = LOAD_WAIT;
            end
          end
        end
      end
      // Registered BRAM output is valid now; format and capture it.
      LOAD_WAIT: begin
        rdata_d = ld_data;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      ld_off_q  <= 2'b00;
      ld_size_q <= SIZE_BYTE;
      ld_uns_q  <= 1'b0;
      rdata_q   <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ld_off_q  <= ld_off_d;
      ld_size_q <= ld_size_d;
      ld_uns_q  <= ld_uns_d;
      rdata_q   <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q   <= fault_d;
`endif
    end
  end

  assign bus.resp_valid = (state_q == RESP) && !reset;
  assign bus.resp_rdata = rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.resp_fault = fault_q;
`else
  assign bus.resp_fault = 1'b0;
`endif

  // Only trap mode needs the unused-in-default trap flag; keep it referenced.
  logic unused_trap;
  assign unused_trap = trap;

endmodule

// File: tb/tb_lsu_port.sv
// tb_lsu_port: directed, table-driven bench for lsu_port with a registered-read BRAM model.
// Ports: none (top-level bench); instantiates lsu_port_if and lsu_port.
// Expected values are hand-computed per build option (LSU_MISALIGN_TRAP_EN).
module tb_lsu_port;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lsu_port_if #(.AW(13)) bus ();

  lsu_port #(.MEM_SIZE(8192)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Word-organised BRAM model with one-cycle registered read.
  logic [31:0] mem [0:2047];
  logic        pre_we;
  logic [10:0] pre_idx;
  logic [31:0] pre_dat;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_dat;
    end else if (bus.mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_ben[b]) mem[bus.mem_addr[12:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
    end
    bus.mem_rdata <= mem[bus.mem_addr[12:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic        e_we;
    logic [3:0]  e_ben;
    logic [31:0] e_wdata;
    logic [12:0] e_addr;
    logic [31:0] e_rdata;
    logic        e_fault;
    logic        e_load;   // response two cycles after accept
  } vec_t;

  function automatic vec_t ld(input logic [1:0] sz, input logic u, input logic [12:0] a,
                              input logic [3:0] ben, input logic [31:0] rd);
    vec_t v;
    v = '{we:1'b0, size:sz, uns:u, addr:a, wdata:32'h0, e_we:1'b0, e_ben:ben,
          e_wdata:32'h0, e_addr:a, e_rdata:rd, e_fault:1'b0, e_load:1'b1};
    return v;
  endfunction

  function automatic vec_t st(input logic [1:0] sz, input logic [12:0] a, input logic [31:0] wd,
                              input logic [3:0] ben, input logic [31:0] ewd);
    vec_t v;
    v = '{we:1'b1, size:sz, uns:1'b0, addr:a, wdata:wd, e_we:1'b1, e_ben:ben,
          e_wdata:ewd, e_addr:a, e_rdata:32'h0, e_fault:1'b0, e_load:1'b0};
    return v;
  endfunction

  // Misaligned request in trap mode: accepted, no memory access, fault response at N+1.
  function automatic vec_t fault_vec(input logic w, input logic [1:0] sz, input logic [12:0] a);
    vec_t v;
    v = '{we:w, size:sz, uns:1'b0, addr:a, wdata:32'h0, e_we:1'b0, e_ben:4'b0000,
          e_wdata:32'h0, e_addr:a, e_rdata:32'h0, e_fault:1'b1, e_load:1'b0};
    return v;
  endfunction

  vec_t vecs [0:20];

  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    #1;
    chk({p, " ready@N"}, bus.req_ready, 1'b1);
    chk({p, " mem_we@N"}, bus.mem_we, v.e_we);
    chk({p, " mem_ben@N"}, bus.mem_ben, v.e_ben);
    chk({p, " mem_addr@N"}, bus.mem_addr, v.e_addr);
    if (v.e_we) chk({p, " mem_wdata@N"}, bus.mem_wdata, v.e_wdata);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk({p, " ready@N+1"}, bus.req_ready, 1'b0);
    chk({p, " mem_we@N+1"}, bus.mem_we, 1'b0);
    chk({p, " mem_ben@N+1"}, bus.mem_ben, 4'b0000);
    chk({p, " mem_addr hold"}, bus.mem_addr, v.e_addr);
    if (v.e_load) begin
      chk({p, " resp_valid@N+1"}, bus.resp_valid, 1'b0);
      @(negedge clk);
      #1;
    end
    chk({p, " resp_valid"}, bus.resp_valid, 1'b1);
    chk({p, " resp_rdata"}, bus.resp_rdata, v.e_rdata);
    chk({p, " resp_fault"}, bus.resp_fault, v.e_fault);
    @(negedge clk);
    #1;
    chk({p, " resp_valid after"}, bus.resp_valid, 1'b0);
    chk({p, " ready after"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    pre_we           = 1'b0;
    pre_idx          = '0;
    pre_dat          = '0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    // Memory evolution: word 0x10 starts 884422F1; sb/sb restore; sh -> 123422F1;
    // misaligned sh 0x11 (non-trap: half at 0x10) -> 12345678.
    vecs[0]  = ld(2'b00, 1'b0, 13'h13, 4'b1000, 32'hFFFF_FF88);
    vecs[1]  = ld(2'b00, 1'b1, 13'h13, 4'b1000, 32'h0000_0088);
    vecs[2]  = ld(2'b01, 1'b0, 13'h12, 4'b1100, 32'hFFFF_8844);
    vecs[3]  = ld(2'b01, 1'b1, 13'h10, 4'b0011, 32'h0000_22F1);
    vecs[4]  = ld(2'b10, 1'b0, 13'h10, 4'b1111, 32'h8844_22F1);
    vecs[5]  = ld(2'b00, 1'b0, 13'h10, 4'b0001, 32'hFFFF_FFF1);
    vecs[6]  = st(2'b00, 13'h11, 32'h0000_00AB, 4'b0010, 32'hABAB_ABAB);
    vecs[7]  = ld(2'b10, 1'b0, 13'h10, 4'b1111, 32'h8844_ABF1);
    vecs[8]  = st(2'b00, 13'h11, 32'h0000_0022, 4'b0010, 32'h2222_2222);
    vecs[9]  = st(2'b01, 13'h12, 32'h0000_1234, 4'b1100, 32'h1234_1234);
    vecs[10] = ld(2'b10, 1'b0, 13'h10, 4'b1111, 32'h1234_22F1);
    if (TRAP) vecs[11] = fault_vec(1'b0, 2'b10, 13'h11);
    else begin
      vecs[11] = ld(2'b10, 1'b0, 13'h11, 4'b1111, 32'h1234_22F1);
      vecs[11].e_addr = 13'h10;
    end
    if (TRAP) vecs[12] = fault_vec(1'b0, 2'b01, 13'h13);
    else begin
      vecs[12] = ld(2'b01, 1'b0, 13'h13, 4'b1100, 32'h0000_1234);
      vecs[12].e_addr = 13'h12;
    end
    vecs[13] = ld(2'b11, 1'b0, 13'h10, 4'b1111, 32'h1234_22F1);
    vecs[14] = st(2'b10, 13'h14, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
    vecs[15] = ld(2'b00, 1'b0, 13'h15, 4'b0010, 32'hFFFF_FFBE);
    vecs[16] = ld(2'b01, 1'b1, 13'h16, 4'b1100, 32'h0000_DEAD);
    vecs[17] = ld(2'b01, 1'b0, 13'h16, 4'b1100, 32'hFFFF_DEAD);
    if (TRAP) vecs[18] = fault_vec(1'b1, 2'b01, 13'h11);
    else begin
      vecs[18] = st(2'b01, 13'h11, 32'h0000_5678, 4'b0011, 32'h5678_5678);
      vecs[18].e_addr = 13'h10;
    end
    vecs[19] = ld(2'b10, 1'b0, 13'h10, 4'b1111, TRAP ? 32'h1234_22F1 : 32'h1234_5678);
    vecs[20] = ld(2'b00, 1'b1, 13'h12, 4'b0100, 32'h0000_0034);

    // Reset state.
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = 11'd4;
    pre_dat = 32'h8844_22F1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 13'h10;
    #1;
    chk("rst ready", bus.req_ready, 1'b0);
    chk("rst mem_we", bus.mem_we, 1'b0);
    chk("rst mem_ben", bus.mem_ben, 4'b0000);
    @(negedge clk);
    pre_we        = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("rst resp_valid", bus.resp_valid, 1'b0);
    chk("rst resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst resp_fault", bus.resp_fault, 1'b0);
    reset = 1'b0;
    #1;
    chk("post-rst ready", bus.req_ready, 1'b1);

    for (int i = 0; i < 21; i++) run_vec(i, vecs[i]);

    // Back-to-back: req_valid held high across two lbu 0x12 loads.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b1;
    bus.req_addr     = 13'h12;
    #1;
    chk("b2b ready N", bus.req_ready, 1'b1);
    chk("b2b ben N", bus.mem_ben, 4'b0100);
    @(negedge clk); #1;
    chk("b2b ready N+1", bus.req_ready, 1'b0);
    @(negedge clk); #1;
    chk("b2b ready N+2", bus.req_ready, 1'b0);
    chk("b2b resp_valid N+2", bus.resp_valid, 1'b1);
    chk("b2b rdata N+2", bus.resp_rdata, 32'h0000_0034);
    @(negedge clk); #1;
    chk("b2b ready N+3", bus.req_ready, 1'b1);
    chk("b2b ben N+3", bus.mem_ben, 4'b0100);
    chk("b2b resp_valid N+3", bus.resp_valid, 1'b0);
    @(negedge clk); #1;
    chk("b2b ready N+4", bus.req_ready, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("b2b resp_valid N+5", bus.resp_valid, 1'b1);
    chk("b2b rdata N+5", bus.resp_rdata, 32'h0000_0034);

    // Reset during LOAD_WAIT, with a store offered while reset is high.
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_addr     = 13'h10;
    #1;
    chk("rstmid accept", bus.req_ready, 1'b1);
    @(negedge clk);
    reset          = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_wdata  = 32'hFFFF_FFFF;
    #1;
    chk("rstmid ready", bus.req_ready, 1'b0);
    chk("rstmid mem_we", bus.mem_we, 1'b0);
    chk("rstmid mem_ben", bus.mem_ben, 4'b0000);
    chk("rstmid resp_valid", bus.resp_valid, 1'b0);
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("rstmid ready after", bus.req_ready, 1'b1);
    chk("rstmid no resp 1", bus.resp_valid, 1'b0);
    @(negedge clk); #1;
    chk("rstmid no resp 2", bus.resp_valid, 1'b0);
    chk("rstmid mem intact", mem[4], TRAP ? 32'h1234_22F1 : 32'h1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_port.md
Name: lsu_port

Overview:
- Load/store initiator that drives the data port (port B) of the dual-port BRAM main memory.
- Accepts one CPU load/store request at a time.
- For stores: generates byte enables and replicates write data into the correct lanes.
- For loads: absorbs the 1-cycle registered BRAM read latency, then extracts, shifts and sign/zero-extends the read data.
- Sits between the core's memory stage and the memory's port B.

Parameters:
- MEM_SIZE, 8192, bytes of backing memory; address width is $clog2(MEM_SIZE).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  $clog2(MEM_SIZE)  byte address
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_unsigned  in  1  load zero-extends when 1
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  formatted load data (0 for stores)
- resp_fault  out  1  misalignment fault, qualified by resp_valid
- mem_addr  out  $clog2(MEM_SIZE)  to memory addr_b
- mem_wdata  out  32  to memory data_i_b
- mem_ben  out  4  to memory data_en_b
- mem_we  out  1  to memory write_en_b
- mem_rdata  in  32  from memory data_o_b (valid the cycle after the address)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_fault 0.
- While reset is high: req_ready 0, mem_we 0, mem_ben 0.
- FSM states:
  - IDLE: req_ready = 1.
  - LOAD_WAIT: req_ready = 0.
  - RESP: req_ready = 0; resp_valid = 1 for exactly this one cycle; then → IDLE.
- Accept: req_valid && req_ready, in cycle N.
  - mem_addr, mem_ben, mem_we and mem_wdata are driven combinationally from req_* in cycle N only.
  - In all other cycles mem_we = 0, mem_ben = 0, and mem_addr holds the last value.
- Store: mem_we = 1 in cycle N, then → RESP. resp_valid in N+1, resp_rdata = 0.
- Load: mem_we = 0 in cycle N, then → LOAD_WAIT, latching offset = addr[1:0], size and unsigned.
  - In LOAD_WAIT (N+1), mem_rdata is formatted and registered; → RESP.
  - resp_valid in N+2.
- Throughput: stores one per 2 cycles, loads one per 3 cycles. No response backpressure.
- Byte enables:
  - byte: 4'b0001 << off
  - half: 4'b0011 << {off[1], 1'b0}
  - word: 4'b1111
- Write data lanes:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load formatting: shifted = mem_rdata >> (8*off).
  - byte: bits [7:0], sign-extended from bit 7 unless unsigned.
  - half: bits [15:0], sign-extended from bit 15 unless unsigned.
  - word: unchanged; req_unsigned is ignored.
- Misaligned access: half with off[0] = 1, or word with off != 0 (handling set by the optional feature).
- Reset mid-operation: in-flight load is discarded and no resp_valid is issued. No write can occur after reset asserts.
- req_* is ignored outside IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request is accepted but no memory access is made (mem_we 0, mem_ben 0). FSM goes → RESP; resp_valid in N+1 with resp_fault = 1 and resp_rdata = 0.
- Undefined: offending low address bits are forced to 0 (half clears off[0]; word uses off 0) and the access proceeds normally. resp_fault is tied to 0.

Decomposition:
- lsu_pkg holds:
  - size_t enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD)
  - lsu_state_t enum (IDLE, LOAD_WAIT, RESP)
  - ben/lane helper functions
- One combinational sub-module, lsu_align: store lane/byte-enable generation plus load extract/extend. Unit-testable standalone.

Test Plan:
- Preload word 0x10 = 0x884422F1. lb 0x13 → resp_valid at N+2, rdata 0xFFFFFF88; lbu 0x13 → 0x00000088.
- lh 0x12 → 0xFFFF8844; lhu 0x10 → 0x000022F1; lw 0x10 → 0x884422F1.
- sb 0x11 wdata 0x000000AB → cycle N: mem_ben 0010, mem_wdata 0xABABABAB, resp_valid N+1. Then lw 0x10 → 0x8844ABF1.
- sh 0x12 wdata 0x1234 → mem_ben 1100, mem_wdata 0x12341234. Then lw 0x10 → 0x123422F1.
- lw 0x11:
  - With LSU_MISALIGN_TRAP_EN: resp_fault = 1 at N+1, rdata 0, no memory access.
  - Without: rdata = word at 0x10, fault 0.
- Back-to-back req_valid held high: req_ready low in LOAD_WAIT/RESP; second request accepted in the cycle after RESP. Assert reset during LOAD_WAIT → no resp_valid, req_ready 1 in the first cycle after reset deasserts.
